// File: rtl/arb_request_client_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_request_client_if : upstream, arbiter and downstream handshakes       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface arb_request_client_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_tail;
  logic             req;
  logic             gnt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             rel;
  logic [CW-1:0]    count;
  logic             err_gnt;

  modport slave (
    input  in_valid, in_data, in_tail, gnt, out_ready,
    output in_ready, req, out_valid, out_data, rel, count, err_gnt
  );

  modport master (
    output in_valid, in_data, in_tail, gnt, out_ready,
    input  in_ready, req, out_valid, out_data, rel, count, err_gnt
  );
endinterface
`default_nettype wire

// File: rtl/arb_request_client.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_request_client : per-port FIFO + locked request to round-robin arb   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module arb_request_client #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  arb_request_client_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_req;
  logic           r_err;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [WIDTH:0] r_mem [DEPTH];

  logic           w_full;
  logic           w_nonempty;
  logic           w_push;
  logic           w_fire;
  logic [WIDTH:0] w_head;
  logic           w_head_tail;
  logic [CW-1:0]  w_count_nxt;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_nonempty  = (r_count != '0);
  assign w_push      = bus.in_valid & ~w_full;
  assign w_fire      = r_req & bus.gnt & bus.out_ready & w_nonempty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_tail = w_head[WIDTH];
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_fire);

  assign bus.in_ready  = ~w_full;
  assign bus.req       = r_req;
  assign bus.out_valid = r_req & bus.gnt & w_nonempty;
  assign bus.out_data  = w_head[WIDTH-1:0];
  assign bus.rel       = w_fire & w_head_tail;
  assign bus.count     = r_count;
  assign bus.err_gnt   = r_err;

  // Storage carries no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_tail, bus.in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_req    <= 1'b0;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (bus.gnt & ~r_req) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          // Look at the post-edge occupancy so a fresh flit requests in the cycle it appears.
          if (w_count_nxt != '0) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (w_fire) begin
            if (!w_head_tail) begin
              r_state <= ST_LOCK;
            end else if (r_count == CW'(1)) begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        ST_LOCK: begin
          if (w_fire && w_head_tail) begin
            if (r_count > CW'(1)) begin
              r_state <= ST_REQ;
            end else begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_arb_request_client.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_arb_request_client : vector table, corner sequences, random vs model  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_arb_request_client;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_request_client_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  arb_request_client #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a queue of {tail,data} plus whether the port is currently requesting.
  logic [WIDTH:0] mq [$];
  bit             m_req = 1'b0;
  bit             m_err = 1'b0;

  typedef struct {
    bit          iv;
    logic [63:0] d;
    bit          t;
    bit          g;
    bit          r;
    bit          e_req;
    bit          e_ov;
    bit          e_rel;
    logic [63:0] e_cnt;
    logic [63:0] e_data;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_req = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic apply(input bit iv, input logic [63:0] d, input bit t, input bit g, input bit r);
    int             sz;
    bit             ov;
    logic [WIDTH:0] head;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_tail   = t;
    bus.gnt       = g;
    bus.out_ready = r;
    @(negedge clk);
    sz   = mq.size();
    head = (sz != 0) ? mq[0] : '0;
    ov   = m_req && g && (sz != 0);
    chk("m_req",       64'(bus.req),       64'(m_req));
    chk("m_out_valid", 64'(bus.out_valid), 64'(ov));
    chk("m_rel",       64'(bus.rel),       64'(ov && r && head[WIDTH]));
    chk("m_count",     64'(bus.count),     64'(sz));
    chk("m_in_ready",  64'(bus.in_ready),  64'(sz != DEPTH));
    chk("m_err_gnt",   64'(bus.err_gnt),   64'(m_err));
    if (ov) chk("m_out_data", bus.out_data, head[WIDTH-1:0]);
  endtask

  task automatic tick();
    int sz;
    bit fire;
    bit ht;
    sz   = mq.size();
    fire = m_req && bus.gnt && bus.out_ready && (sz != 0);
    ht   = 1'b0;
    if (fire) begin
      ht = mq[0][WIDTH];
      void'(mq.pop_front());
    end
    if (bus.in_valid && sz < DEPTH) mq.push_back({bus.in_tail, bus.in_data});
    if (bus.gnt && !m_req) m_err = 1'b1;
    if (!m_req)          m_req = (mq.size() != 0);
    else if (fire && ht) m_req = (sz > 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-flit packet, then 3-flit packet with a 2-cycle downstream stall on 0x2.
    vecs[0] = '{1, 64'hA5, 1, 0, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 64'h0,  0, 1, 1, 1, 1, 1, 1, 64'hA5};
    vecs[2] = '{0, 64'h0,  0, 0, 1, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 64'h1,  0, 0, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{1, 64'h2,  0, 1, 1, 1, 1, 0, 1, 64'h1};
    vecs[5] = '{1, 64'h3,  1, 1, 0, 1, 1, 0, 1, 64'h2};
    vecs[6] = '{0, 64'h0,  0, 1, 0, 1, 1, 0, 2, 64'h2};
    vecs[7] = '{0, 64'h0,  0, 1, 1, 1, 1, 0, 2, 64'h2};
    vecs[8] = '{0, 64'h0,  0, 1, 1, 1, 1, 1, 1, 64'h3};
    vecs[9] = '{0, 64'h0,  0, 0, 1, 0, 0, 0, 0, 0};

    bus.in_valid = 0; bus.in_data = '0; bus.in_tail = 0; bus.gnt = 0; bus.out_ready = 0;
    rst_n = 1'b0;
    #12;
    chk("t1_req",      64'(bus.req),       64'd0);
    chk("t1_out_valid",64'(bus.out_valid), 64'd0);
    chk("t1_rel",      64'(bus.rel),       64'd0);
    chk("t1_count",    64'(bus.count),     64'd0);
    chk("t1_in_ready", 64'(bus.in_ready),  64'd1);
    chk("t1_err_gnt",  64'(bus.err_gnt),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) begin
      apply(0, 0, 0, 0, 0);
      chk("t1_idle_req", 64'(bus.req), 64'd0);
      tick();
    end

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].iv, vecs[i].d, vecs[i].t, vecs[i].g, vecs[i].r);
      chk($sformatf("vec%0d_req", i),   64'(bus.req),       64'(vecs[i].e_req));
      chk($sformatf("vec%0d_ov", i),    64'(bus.out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d_rel", i),   64'(bus.rel),       64'(vecs[i].e_rel));
      chk($sformatf("vec%0d_count", i), 64'(bus.count),     vecs[i].e_cnt);
      if (vecs[i].e_ov) chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].e_data);
      tick();
    end

    // Fill past capacity while not granted, then drain across the pointer wrap.
    for (int i = 0; i < 9; i++) begin
      apply(1, 64'h40 + 64'(i), i == 7, 0, 1);
      if (i == 8) begin
        chk("t4_full_ready", 64'(bus.in_ready), 64'd0);
        chk("t4_full_count", 64'(bus.count),    64'd8);
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      apply(0, 0, 0, 1, 1);
      chk($sformatf("t4_drain%0d_data", i), bus.out_data, 64'h40 + 64'(i));
      chk($sformatf("t4_drain%0d_rel", i),  64'(bus.rel), 64'(i == 7));
      tick();
    end
    apply(0, 0, 0, 0, 0);
    chk("t4_empty_count", 64'(bus.count), 64'd0);
    chk("t4_empty_req",   64'(bus.req),   64'd0);
    tick();

    // Mid-packet underflow keeps the request and stalls.
    apply(1, 64'h10, 0, 0, 0); tick();
    apply(0, 0, 0, 1, 1);
    chk("t5_head_data", bus.out_data, 64'h10);
    chk("t5_head_rel",  64'(bus.rel), 64'd0);
    tick();
    repeat (3) begin
      apply(0, 0, 0, 1, 1);
      chk("t5_stall_req", 64'(bus.req),       64'd1);
      chk("t5_stall_ov",  64'(bus.out_valid), 64'd0);
      chk("t5_stall_rel", 64'(bus.rel),       64'd0);
      tick();
    end
    apply(1, 64'h11, 1, 1, 1);
    chk("t5_write_ov", 64'(bus.out_valid), 64'd0);
    tick();
    apply(0, 0, 0, 1, 1);
    chk("t5_tail_data", bus.out_data,       64'h11);
    chk("t5_tail_ov",   64'(bus.out_valid), 64'd1);
    chk("t5_tail_rel",  64'(bus.rel),       64'd1);
    tick();
    apply(0, 0, 0, 0, 0);
    chk("t5_after_req", 64'(bus.req), 64'd0);
    tick();

    // Spurious grant sets a sticky error; async reset in LOCK clears everything.
    apply(0, 0, 0, 1, 0);
    chk("t6_err_before", 64'(bus.err_gnt), 64'd0);
    tick();
    repeat (3) begin
      apply(0, 0, 0, 0, 0);
      chk("t6_err_sticky", 64'(bus.err_gnt), 64'd1);
      tick();
    end
    apply(1, 64'h20, 0, 0, 0); tick();
    apply(1, 64'h21, 0, 1, 1); tick();
    apply(0, 0, 0, 0, 0);
    chk("t6_lock_req", 64'(bus.req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",      64'(bus.req),       64'd0);
    chk("t6_rst_count",    64'(bus.count),     64'd0);
    chk("t6_rst_err",      64'(bus.err_gnt),   64'd0);
    chk("t6_rst_ov",       64'(bus.out_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(bus.in_ready),  64'd1);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (3000) begin
      bit g;
      g = m_req ? ($urandom_range(3) != 0) : ($urandom_range(199) == 0);
      apply($urandom_range(1) == 1, {$urandom, $urandom}, $urandom_range(2) == 0,
            g, $urandom_range(3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
